// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, IF/ID register,
// redirect draining, HALT detection and a one-entry skid for decode stalls.
module pc_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch2_idex,
    input  logic [15:0] branch_target,
    input  logic        putPCback,
    input  logic [15:0] execPCadded,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_ifid,
    output logic [15:0] pc_added_ifid,
    output logic        valid_ifid,
    output logic        halted
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   pending_q, pending_d;
    logic           outstanding_q, outstanding_d;
    logic           skid_valid_q, skid_valid_d;
    logic [W-1:0]   skid_instr_q, skid_instr_d;
    logic [W-1:0]   skid_pc_q, skid_pc_d;
    logic [W-1:0]   instr_q, instr_d;
    logic [W-1:0]   pc_added_q, pc_added_d;
    logic           valid_q, valid_d;
    logic           halted_q, halted_d;

    logic           redirect;
    logic [W-1:0]   target;
    logic [W-1:0]   pc_inc;
    logic           req;
    logic           accept;

    assign redirect = putPCback | branch2_idex;
    assign target   = putPCback ? execPCadded : branch_target;
    assign pc_inc   = pc_q + W'(1);

    // Request is held through DRAIN; in FETCH a raised request survives a stall.
    assign req = !rst &&
                 (((state_q == S_FETCH) && !skid_valid_q && (!stall || outstanding_q)) ||
                  (state_q == S_DRAIN));
    assign accept = (state_q == S_FETCH) && req && imem_ack;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        outstanding_d = req && !imem_ack;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_d       = instr_q;
        pc_added_d    = pc_added_q;
        valid_d       = valid_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    if (!outstanding_q || imem_ack) begin
                        pc_d          = target;
                        outstanding_d = 1'b0;
                    end else begin
                        pending_d = target;
                        state_d   = S_DRAIN;
                    end
                end else if (accept) begin
                    if (!stall) begin
                        instr_d    = imem_rdata;
                        pc_added_d = pc_inc;
                        valid_d    = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_inc;
                        skid_valid_d = 1'b1;
                    end
                    pc_d = pc_inc;
                    if (imem_rdata[15:12] == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end
                end else if (!stall) begin
                    if (skid_valid_q) begin
                        instr_d      = skid_instr_q;
                        pc_added_d   = skid_pc_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                if (redirect) begin
                    pending_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                outstanding_d = 1'b0;
                if (redirect) begin
                    pc_d         = target;
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    state_d      = S_FETCH;
                end else if (!stall) begin
                    // A HALT word captured under stall still drains to decode.
                    if (skid_valid_q) begin
                        instr_d      = skid_instr_q;
                        pc_added_d   = skid_pc_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            pending_q     <= '0;
            outstanding_q <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            instr_q       <= '0;
            pc_added_q    <= '0;
            valid_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_q       <= instr_d;
            pc_added_q    <= pc_added_d;
            valid_q       <= valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req      = req;
    assign imem_addr     = pc_q;
    assign instr_ifid    = instr_q;
    assign pc_added_ifid = pc_added_q;
    assign valid_ifid    = valid_q;
    assign halted        = halted_q;

endmodule
